i2s_driver: RTL and testbench



---
 rtl/i2s_driver_if.sv | 22 ++
 rtl/i2s_driver.sv | 80 ++++++++
 tb/tb_i2s_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_driver_if.sv
// Pin bundle between the audio sample datapath, the I2S serializer and the DAC.
// Member suffixes give the direction seen from the serializer.
interface i2s_driver_if;
  logic [15:0] data_l_i;
  logic [15:0] data_r_i;
  logic        bck_o;
  logic        ws_o;
  logic        datai_o;
  logic        range_o;
  logic        deem_o;
  logic        latch_o;

  modport master (
    input  data_l_i, data_r_i,
    output bck_o, ws_o, datai_o, range_o, deem_o, latch_o
  );

  modport slave (
    output data_l_i, data_r_i,
    input  bck_o, ws_o, datai_o, range_o, deem_o, latch_o
  );
endinterface

// File: rtl/i2s_driver.sv
// Philips I2S serializer: 16-bit left/right samples, 32 BCK slots per frame.
// WS/DATAI/LATCH move only on the CLK edge where BCK falls.
module i2s_driver #(
  parameter int   BCK_DIV   = 4,
  parameter logic RANGE_VAL = 1'b0,
  parameter logic DEEM_VAL  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  i2s_driver_if.master  bus
);
  localparam int              DIV_W    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bck_q, bck_d;
  logic [4:0]       slot_q, slot_d;
  logic [31:0]      sr_q, sr_d;
  logic             ws_q, ws_d;
  logic             datai_q, datai_d;
  logic             latch_q, latch_d;
  logic             tick;
  logic             fall;

  assign tick = (div_q == DIV_LAST);
  assign fall = tick & bck_q;

  always_comb begin
    div_d   = div_q + DIV_W'(1);
    bck_d   = bck_q;
    slot_d  = slot_q;
    sr_d    = sr_q;
    ws_d    = ws_q;
    datai_d = datai_q;
    latch_d = 1'b0;
    if (tick) begin
      div_d = '0;
      bck_d = ~bck_q;
    end
    if (fall) begin
      slot_d = slot_q + 5'd1;
      if (slot_d == 5'd0) begin
        sr_d    = {bus.data_l_i, bus.data_r_i};
        latch_d = 1'b1;
      end else begin
        sr_d = sr_q << 1;
      end
      // WS leads each channel's MSB by one slot.
      ws_d    = (slot_d >= 5'd15) && (slot_d <= 5'd30);
      datai_d = sr_d[31];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bck_q   <= 1'b0;
      slot_q  <= 5'd31;
      sr_q    <= '0;
      ws_q    <= 1'b0;
      datai_q <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bck_q   <= bck_d;
      slot_q  <= slot_d;
      sr_q    <= sr_d;
      ws_q    <= ws_d;
      datai_q <= datai_d;
      latch_q <= latch_d;
    end
  end

  assign bus.bck_o   = bck_q;
  assign bus.ws_o    = ws_q;
  assign bus.datai_o = datai_q;
  assign bus.latch_o = latch_q;
  assign bus.range_o = RANGE_VAL;
  assign bus.deem_o  = DEEM_VAL;
endmodule

// File: tb/tb_i2s_driver.sv
// Randomized bench for i2s_driver (BCK_DIV = 4 and 1) against a timing model
// derived from edge counts since reset release.
module tb_i2s_driver;
  localparam logic RANGE_V = 1'b1;
  localparam logic DEEM_V  = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_driver_if bus4 ();
  i2s_driver_if bus1 ();

  i2s_driver #(.BCK_DIV(4), .RANGE_VAL(RANGE_V), .DEEM_VAL(DEEM_V)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  i2s_driver #(.BCK_DIV(1), .RANGE_VAL(RANGE_V), .DEEM_VAL(DEEM_V)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [15:0] dl, dr;
  assign bus4.data_l_i = dl;
  assign bus4.data_r_i = dr;
  assign bus1.data_l_i = dl;
  assign bus1.data_r_i = dr;

  int n_tests = 0;
  int n_fail  = 0;
  int t;
  logic [31:0] word4, word1;
  logic [31:0] cap_q[$];
  logic [31:0] coll;
  int   rises;
  int   frames_done;
  logic captured_any;
  logic prev_bck;
  logic directed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic logic is_capture(input int tt, input int b);
    return (tt > 0) && (tt % (2 * b) == 0) && (((tt / (2 * b)) - 1) % 32 == 0);
  endfunction

  // Expected pins after tt rising edges since release, from BCK/slot arithmetic.
  task automatic check_pins(input string tag, input int b, input logic [31:0] word,
                            input logic bck, input logic ws, input logic dat,
                            input logic lat, input logic rng, input logic dem);
    int m, slot;
    logic e_ws, e_dat, e_lat;
    m = t / (2 * b);
    e_ws = 1'b0; e_dat = 1'b0; e_lat = 1'b0;
    if (m > 0) begin
      slot  = (m - 1) % 32;
      e_dat = word[31 - slot];
      e_ws  = (slot >= 15) && (slot <= 30);
      e_lat = (t == 2 * b * m) && (slot == 0);
    end
    check_eq({tag, "_bck"},   bck, 32'((t / b) % 2));
    check_eq({tag, "_ws"},    ws,  e_ws);
    check_eq({tag, "_datai"}, dat, e_dat);
    check_eq({tag, "_latch"}, lat, e_lat);
    check_eq({tag, "_range"}, rng, RANGE_V);
    check_eq({tag, "_deem"},  dem, DEEM_V);
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_bck4"},   bus4.bck_o,   1'b0);
    check_eq({tag, "_ws4"},    bus4.ws_o,    1'b0);
    check_eq({tag, "_datai4"}, bus4.datai_o, 1'b0);
    check_eq({tag, "_latch4"}, bus4.latch_o, 1'b0);
    check_eq({tag, "_range4"}, bus4.range_o, RANGE_V);
    check_eq({tag, "_deem4"},  bus4.deem_o,  DEEM_V);
    check_eq({tag, "_bck1"},   bus1.bck_o,   1'b0);
    check_eq({tag, "_datai1"}, bus1.datai_o, 1'b0);
    check_eq({tag, "_latch1"}, bus1.latch_o, 1'b0);
  endtask

  task automatic clear_model();
    t = 0;
    cap_q.delete();
    rises = 0;
    frames_done = 0;
    captured_any = 1'b0;
    prev_bck = 1'b0;
    coll = '0;
  endtask

  // One CLK cycle: sample at negedge, advance model, compare.
  task automatic step();
    logic [31:0] dir_exp[3];
    dir_exp[0] = 32'h0AA0A00A;
    dir_exp[1] = 32'h0FFF0000;
    dir_exp[2] = 32'h80007FFF;
    @(negedge clk);
    t++;
    if (is_capture(t, 4)) begin
      word4 = {dl, dr};
      cap_q.push_back(word4);
      captured_any = 1'b1;
    end
    if (is_capture(t, 1)) word1 = {dl, dr};
    check_pins("d4", 4, word4, bus4.bck_o, bus4.ws_o, bus4.datai_o,
               bus4.latch_o, bus4.range_o, bus4.deem_o);
    check_pins("d1", 1, word1, bus1.bck_o, bus1.ws_o, bus1.datai_o,
               bus1.latch_o, bus1.range_o, bus1.deem_o);
    // Reassemble the word a DAC would see on BCK rises.
    if (bus4.bck_o && !prev_bck && captured_any) begin
      coll = {coll[30:0], bus4.datai_o};
      rises++;
      if (rises == 32) begin
        check_eq("frame_word", coll, cap_q.pop_front());
        if (directed && frames_done < 3)
          check_eq("frame_directed", coll, dir_exp[frames_done]);
        $display("[TB] frame %0d word=%08h", frames_done, coll);
        frames_done++;
        rises = 0;
      end
    end
    prev_bck = bus4.bck_o;
  endtask

  task automatic hit_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_pins(tag);
    repeat (3) @(negedge clk);
    check_reset_pins({tag, "_hold"});
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    int phase, cyc, f, slot, rnd_slot;
    dl = 16'h0AA0;
    dr = 16'hA00A;
    word4 = '0;
    word1 = '0;
    directed = 1'b1;
    phase = 0;
    cyc = 0;
    rnd_slot = int'($urandom_range(1, 30));
    clear_model();
    #100;
    check_reset_pins("por");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    while (phase != 5 && cyc < 20000) begin
      step();
      cyc++;
      f = -1; slot = -1;
      if (t > 0 && t % 8 == 0) begin
        f    = (t / 8 - 1) / 32;
        slot = (t / 8 - 1) % 32;
      end
      if (phase >= 3 && $urandom_range(0, 39) == 0) begin
        dl = 16'($urandom);
        dr = 16'($urandom);
      end
      case (phase)
        0: if (f == 0 && slot == 5)  begin dl = 16'h0FFF; dr = 16'h0000; phase = 1; end
        1: if (f == 1 && slot == 10) begin dl = 16'h8000; dr = 16'h7FFF; phase = 2; end
        2: if (f == 3 && slot == 20) begin
             check_eq("frames_before_reset", frames_done, 3);
             directed = 1'b0;
             hit_reset("rst_slot20");
             phase = 3;
           end
        3: if (f == 4 && slot == rnd_slot) begin
             hit_reset("rst_rand");
             phase = 4;
           end
        4: if (f == 2 && slot == 31) phase = 5;
        default: ;
      endcase
    end
    check_eq("finished", phase, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
